// File: rtl/stopwatch_time_counter.sv
// Stopwatch datapath: prescaled BCD SS.hh counter (00.00-59.99) with a freezable display copy.
// Optional macro STOPWATCH_SATURATE_EN: hold at 59.99 with sticky ovf instead of wrapping.
module stopwatch_time_counter #(
    parameter int CYCLES_PER_TICK = 1000000,
    parameter int PRESC_W         = $clog2(CYCLES_PER_TICK)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_regs,
    input  logic       count_enabled,
    input  logic       freeze,
    output logic [3:0] disp_h_ones,
    output logic [3:0] disp_h_tens,
    output logic [3:0] disp_s_ones,
    output logic [3:0] disp_s_tens,
    output logic       tick,
    output logic       ovf
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_TICK - 1);
    localparam logic [15:0]        TIME_MAX   = 16'h5999;

    logic [PRESC_W-1:0] presc;
    logic [15:0]        live_time;
    logic [15:0]        disp_time;
    logic               step;
    logic               at_max;
    logic               advance;

    // Increment a packed {s_tens, s_ones, h_tens, h_ones} BCD time, wrapping 59.99 to 00.00.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd9) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign step   = count_enabled && (presc == PRESC_LAST);
    assign at_max = (live_time == TIME_MAX);

`ifdef STOPWATCH_SATURATE_EN
    assign advance = step && !at_max;
`else
    assign advance = step;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            live_time <= '0;
            disp_time <= '0;
            tick      <= 1'b0;
            ovf       <= 1'b0;
        end else if (init_regs) begin
            presc     <= '0;
            live_time <= '0;
            disp_time <= '0;
            tick      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (count_enabled) begin
                presc <= step ? '0 : presc + 1'b1;
            end
            if (advance) begin
                live_time <= bcd_inc(live_time);
            end
            tick <= advance;
`ifdef STOPWATCH_SATURATE_EN
            // Sticky until init_regs or reset; the prescaler keeps running meanwhile.
            if (step && at_max) begin
                ovf <= 1'b1;
            end
`else
            ovf <= step && at_max;
`endif
            // Display trails live time by one edge and holds while frozen.
            if (!freeze) begin
                disp_time <= live_time;
            end
        end
    end

    assign disp_h_ones = disp_time[3:0];
    assign disp_h_tens = disp_time[7:4];
    assign disp_s_ones = disp_time[11:8];
    assign disp_s_tens = disp_time[15:12];

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench for stopwatch_time_counter (CYCLES_PER_TICK=4), covering both macro builds.
module tb_stopwatch_time_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_regs = 1'b0;
    logic       count_enabled = 1'b0;
    logic       freeze = 1'b0;
    logic [3:0] disp_h_ones, disp_h_tens, disp_s_ones, disp_s_tens;
    logic       tick, ovf;
    logic [15:0] dut_disp;

    stopwatch_time_counter #(.CYCLES_PER_TICK(4)) dut (
        .clk(clk), .reset(reset), .init_regs(init_regs), .count_enabled(count_enabled),
        .freeze(freeze), .disp_h_ones(disp_h_ones), .disp_h_tens(disp_h_tens),
        .disp_s_ones(disp_s_ones), .disp_s_tens(disp_s_tens), .tick(tick), .ovf(ovf)
    );

    always #5 clk = ~clk;
    assign dut_disp = {disp_s_tens, disp_s_ones, disp_h_tens, disp_h_ones};

    typedef struct {
        int          cyc;
        logic [15:0] disp;
        logic        ovf;
    } rec_t;
    rec_t sb_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_tick_seen = 0;
    int tick_base;

    // Reference model in integer hundredths.
    int   m_presc = 0;
    int   m_live = 0;
    int   m_disp = 0;
    logic m_tick = 1'b0;
    logic m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_zero();
        m_presc = 0; m_live = 0; m_disp = 0; m_tick = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_step();
        logic stp;
        if (reset || init_regs) begin
            model_zero();
            return;
        end
        stp = count_enabled && (m_presc == 3);
        if (count_enabled) m_presc = stp ? 0 : m_presc + 1;
        if (!freeze) m_disp = m_live;
        m_tick = 1'b0;
`ifndef STOPWATCH_SATURATE_EN
        m_ovf = 1'b0;
`endif
        if (stp) begin
            if (m_live == 5999) begin
`ifdef STOPWATCH_SATURATE_EN
                m_ovf = 1'b1;
`else
                m_ovf  = 1'b1;
                m_tick = 1'b1;
                m_live = 0;
`endif
            end else begin
                m_live++;
                m_tick = 1'b1;
            end
        end
    endtask

    task automatic run(input int n, input logic en, input logic ini, input logic frz);
        for (int i = 0; i < n; i++) begin
            count_enabled = en;
            init_regs     = ini;
            freeze        = frz;
            @(posedge clk);
            model_step();
            cyc++;
            if (m_tick) sb_q.push_back('{cyc, to_bcd(m_disp), m_ovf});
            #1;
        end
    endtask

    // Every DUT tick must match the next predicted step: cycle, display and ovf.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            n_tick_seen++;
            if (sb_q.size() == 0) begin
                check("tick_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                rec_t r;
                r = sb_q.pop_front();
                check("tick_cycle", 32'(cyc), 32'(r.cyc));
                check("tick_disp", 32'(dut_disp), 32'(r.disp));
                check("tick_ovf", 32'(ovf), 32'(r.ovf));
            end
        end
    end

    initial begin
        // Power-on reset
        run(2, 1'b0, 1'b0, 1'b0);
        check("por_disp", 32'(dut_disp), 32'h0);
        check("por_tick_ovf", {30'd0, tick, ovf}, 32'h0);
        reset = 1'b0;

        // 1: async reset mid-count at 00.07
        run(29, 1'b1, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0);
        check("t1_disp_007", 32'(dut_disp), 32'h0007);
        @(negedge clk);
        #2 reset = 1'b1;
        model_zero();
        #1;
        check("t1_async_disp", 32'(dut_disp), 32'h0);
        check("t1_async_tick_ovf", {30'd0, tick, ovf}, 32'h0);
        run(2, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        run(3, 1'b0, 1'b0, 1'b0);
        check("t1_after_release", 32'(dut_disp), 32'h0);
        check("t1_q_empty", 32'(sb_q.size()), 32'd0);

        // 2: 40 enabled cycles -> 10 steps, 4 apart
        tick_base = n_tick_seen;
        run(40, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t2_disp", 32'(dut_disp), 32'h0010);
        check("t2_ticks", 32'(n_tick_seen - tick_base), 32'd10);

        // 3: partial prescaler count kept across pause
        run(1, 1'b0, 1'b1, 1'b0);
        tick_base = n_tick_seen;
        run(6, 1'b1, 1'b0, 1'b0);
        run(10, 1'b0, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t3_disp", 32'(dut_disp), 32'h0002);
        check("t3_ticks", 32'(n_tick_seen - tick_base), 32'd2);

        // 4: carry chain
        run(1, 1'b0, 1'b1, 1'b0);
        run(36, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t4_disp_009", 32'(dut_disp), 32'h0009);
        run(4, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t4_disp_010", 32'(dut_disp), 32'h0010);
        run(989 * 4, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t4_disp_0999", 32'(dut_disp), 32'h0999);
        run(4, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t4_disp_1000", 32'(dut_disp), 32'h1000);

        // 5: freeze
        run(1, 1'b0, 1'b1, 1'b0);
        run(20, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t5_disp_005", 32'(dut_disp), 32'h0005);
        run(20, 1'b1, 1'b0, 1'b1);
        check("t5_frozen", 32'(dut_disp), 32'h0005);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t5_unfrozen", 32'(dut_disp), 32'h0010);
        run(1, 1'b0, 1'b1, 1'b1);
        check("t5_init_frozen", 32'(dut_disp), 32'h0);

        // 6: terminal 59.99 step
        run(5999 * 4, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t6_disp_5999", 32'(dut_disp), 32'h5999);
        check("t6_ovf_pre", 32'(ovf), 32'd0);
        run(4, 1'b1, 1'b0, 1'b0);
`ifdef STOPWATCH_SATURATE_EN
        check("t6_term_tick", 32'(tick), 32'd0);
        check("t6_term_ovf", 32'(ovf), 32'd1);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t6_hold_disp", 32'(dut_disp), 32'h5999);
        run(8, 1'b1, 1'b0, 1'b0);
        check("t6_hold_ovf", 32'(ovf), 32'd1);
        check("t6_hold_disp2", 32'(dut_disp), 32'h5999);
`else
        check("t6_term_tick", 32'(tick), 32'd1);
        check("t6_term_ovf", 32'(ovf), 32'd1);
        run(1, 1'b0, 1'b0, 1'b0);
        check("t6_wrap_disp", 32'(dut_disp), 32'h0000);
        check("t6_ovf_pulse", {30'd0, tick, ovf}, 32'h0);
`endif
        run(1, 1'b0, 1'b1, 1'b0);
        check("t6_init_ovf", 32'(ovf), 32'd0);
        check("t6_init_disp", 32'(dut_disp), 32'h0);

        @(negedge clk);
        check("q_empty_end", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
Datapath end of the stopwatch control interface. It consumes init_regs and count_enabled from the control FSM. It keeps a BCD elapsed-time value (SS.hh, 00.00 to 59.99, hundredths resolution) driven by a clock prescaler. It presents a freezable display copy of that value to the 7-segment driver.

Parameters:
CYCLES_PER_TICK, 1000000, clk cycles per hundredth-second step; must be >= 2. Use 4 in simulation.
PRESC_W, $clog2(CYCLES_PER_TICK), prescaler width; derived, do not override.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
init_regs  input  1  from control; synchronous clear of prescaler, time and display.
count_enabled  input  1  from control; advance the prescaler while high.
freeze  input  1  split/lap hold; while high, display outputs hold.
disp_h_ones  output  4  display hundredths units, BCD 0-9.
disp_h_tens  output  4  display hundredths tens, BCD 0-9.
disp_s_ones  output  4  display seconds units, BCD 0-9.
disp_s_tens  output  4  display seconds tens, BCD 0-5.
tick  output  1  registered pulse, high 1 cycle after each time increment.
ovf  output  1  wrap/saturation indicator (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-count):
  - prescaler, live time, display digits, tick and ovf all go to 0 immediately.
  - Operation resumes on the first rising edge after reset deasserts.
- Priority at each edge: reset > init_regs > count_enabled > hold.
- init_regs=1:
  - Prescaler, live time and display are cleared to 0 at the edge; tick=0 and ovf=0.
  - This holds regardless of count_enabled and freeze.
- count_enabled=1 and init_regs=0:
  - The prescaler increments by 1.
  - When the prescaler equals CYCLES_PER_TICK-1 at an edge, it reloads to 0 and live time advances by one hundredth at that same edge.
  - Step period is exactly CYCLES_PER_TICK enabled cycles.
- count_enabled=0 and init_regs=0:
  - Prescaler and live time hold.
  - A partial prescaler count is retained across pause and resume; it is not rounded.
- Live time carry chain:
  - h_ones 9 to 0 carries into h_tens.
  - h_tens 9 to 0 carries into s_ones.
  - s_ones 9 to 0 carries into s_tens.
  - s_tens 5 carry is the 59.99 terminal case, handled per Optional Feature.
  - Digits never hold non-BCD values.
- Display:
  - Registered.
  - While freeze=0, display loads live time every edge, so display trails live by 1 cycle.
  - While freeze=1, display holds its value; live time keeps counting underneath.
  - When freeze falls, display resumes tracking at the next edge.
- tick:
  - Registered, asserted for exactly one cycle following each edge at which live time changed by +1 or wrapped.
  - Not asserted on the terminal step when saturated.
- Simultaneous events:
  - Terminal prescaler count coinciding with init_regs: clear wins, no step, no tick.
  - freeze together with init_regs: display cleared to 0.

Optional Feature:
Macro: STOPWATCH_SATURATE_EN.
- Defined:
  - On reaching 59.99, live time holds at 59.99 and further steps are suppressed; the prescaler keeps running.
  - ovf goes high at the edge where 59.99 is reached with a step pending (the step that would exceed 59.99).
  - ovf stays high until init_regs or reset.
- Undefined:
  - 59.99 plus one step wraps to 00.00 and tick fires as usual.
  - ovf pulses high for exactly one cycle, aligned with that tick.

Test Plan (CYCLES_PER_TICK=4):
1. Reset asserted mid-count at live 00.07 -> all outputs 0 immediately, asynchronously and without a clock edge; after release with init_regs=0 and count_enabled=0, outputs stay 0.
2. init_regs=0, count_enabled=1 for 40 cycles from 00.00 -> 10 ticks spaced exactly 4 cycles apart; display 00.10 one cycle after the last step.
3. Enable 6 cycles, disable 10, enable 2 -> exactly 2 steps total (second step lands on enabled cycle 8); display 00.02.
4. Count to 00.09, then 4 more enabled cycles -> display 00.10 with carry; at 09.99 plus one step -> 10.00.
5. freeze=1 at display 00.05, count 20 more cycles -> display stays 00.05; freeze=0 -> next edge shows live 00.10; init_regs=1 with freeze=1 -> display 00.00.
6. Preload to 59.99 by counting (5999 steps) then one more step -> without macro: 00.00, tick=1 and ovf=1 for 1 cycle; with STOPWATCH_SATURATE_EN: stays 59.99, tick=0, ovf held high until init_regs.
